// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares data_mem's single port between NUM_REQ requesters.
// Round-robin grant with an optional locked burst owner, limited to MAX_BURST
// consecutive grants while another requester waits. Every access takes exactly
// 3 cycles from accept to response. Define DMEM_ARB_STATS_EN to add per-requester
// grant counters and a conflict counter.
module dmem_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned MEM_WIDTH      = 32,
    parameter int unsigned MEM_ADDR_WIDTH = 15,
    parameter int unsigned MAX_BURST      = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    input  logic [NUM_REQ-1:0]                  req_lock_i,
    input  logic [NUM_REQ-1:0]                  req_we_i,
    input  logic [NUM_REQ*MEM_ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ*MEM_WIDTH-1:0]        req_wdata_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    output logic [NUM_REQ-1:0]                  rsp_valid_o,
    output logic [MEM_WIDTH-1:0]                rsp_rdata_o,
    output logic                                mem_wea_o,
    output logic [MEM_ADDR_WIDTH-1:0]           mem_addra_o,
    output logic [MEM_WIDTH-1:0]                mem_dina_o,
    input  logic [MEM_WIDTH-1:0]                mem_douta_i
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]               grant_cnt_o,
    output logic [15:0]                         conflict_cnt_o
`endif
);

    localparam int unsigned IdW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

    typedef enum logic [0:0] {StArb, StOwned} state_e;

    state_e              state_q;
    logic [IdW-1:0]      owner_q;
    logic [IdW-1:0]      rr_ptr_q;
    logic [CntW-1:0]     burst_cnt_q;

    logic                gnt_found;
    logic [IdW-1:0]      gnt_id;
    logic [IdW-1:0]      rr_next;
    logic                others_valid;
    logic [CntW-1:0]     run_len;
    logic                keep_lock;
    logic [MEM_ADDR_WIDTH-1:0] sel_addr;
    logic [MEM_WIDTH-1:0]      sel_wdata;

    // Memory-side pipeline: stage 1 drives data_mem, stage 2 waits for douta
    logic                      mem_wea_q;
    logic [MEM_ADDR_WIDTH-1:0] mem_addra_q;
    logic [MEM_WIDTH-1:0]      mem_dina_q;
    logic                      p1_valid_q;
    logic [IdW-1:0]            p1_id_q;
    logic                      p1_we_q;
    logic                      p2_valid_q;
    logic [IdW-1:0]            p2_id_q;
    logic                      p2_we_q;
    logic [NUM_REQ-1:0]        rsp_valid_q;
    logic [MEM_WIDTH-1:0]      rsp_rdata_q;

    // Pick the requester to grant: the owner while locked, else round-robin from rr_ptr
    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_id    = '0;
        if (!rst_i) begin
            if (state_q == StOwned) begin
                gnt_found = req_valid_i[owner_q];
                gnt_id    = owner_q;
            end else begin
                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    idx = (32'(rr_ptr_q) + k) % NUM_REQ;
                    if (!gnt_found && req_valid_i[idx[IdW-1:0]]) begin
                        gnt_found = 1'b1;
                        gnt_id    = idx[IdW-1:0];
                    end
                end
            end
        end
    end

    // Grant vector, competing-request detection and burst bookkeeping
    always_comb begin
        logic [NUM_REQ-1:0] others;
        req_ready_o = '0;
        if (gnt_found) begin
            req_ready_o[gnt_id] = 1'b1;
        end
        others         = req_valid_i;
        others[gnt_id] = 1'b0;
        others_valid   = |others;
        rr_next        = (gnt_id == IdW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        if (state_q == StArb) begin
            run_len = CntW'(1);
        end else begin
            run_len = (burst_cnt_q >= MaxCnt) ? MaxCnt : burst_cnt_q + 1'b1;
        end
        // Counter saturates when nobody else waits, so the burst can continue
        keep_lock = req_lock_i[gnt_id] && !((run_len >= MaxCnt) && others_valid);
        sel_addr  = req_addr_i[32'(gnt_id) * MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
        sel_wdata = req_wdata_i[32'(gnt_id) * MEM_WIDTH +: MEM_WIDTH];
    end

    // Arbitration FSM: round-robin pointer, lock owner and burst counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StArb;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else if (gnt_found) begin
            rr_ptr_q <= rr_next;
            if (keep_lock) begin
                state_q     <= StOwned;
                owner_q     <= gnt_id;
                burst_cnt_q <= run_len;
            end else begin
                state_q     <= StArb;
                burst_cnt_q <= '0;
            end
        end else if (state_q == StOwned && !req_valid_i[owner_q]) begin
            // Owner dropped valid: ownership released, rr_ptr already past it
            state_q     <= StArb;
            burst_cnt_q <= '0;
        end
    end

    // Access pipeline: register memory controls, then tag and return the response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_wea_q   <= 1'b0;
            mem_addra_q <= '0;
            mem_dina_q  <= '0;
            p1_valid_q  <= 1'b0;
            p1_id_q     <= '0;
            p1_we_q     <= 1'b0;
            p2_valid_q  <= 1'b0;
            p2_id_q     <= '0;
            p2_we_q     <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            mem_wea_q <= gnt_found & req_we_i[gnt_id];
            if (gnt_found) begin
                mem_addra_q <= sel_addr;
                mem_dina_q  <= sel_wdata;
            end
            p1_valid_q  <= gnt_found;
            p1_id_q     <= gnt_id;
            p1_we_q     <= req_we_i[gnt_id];
            p2_valid_q  <= p1_valid_q;
            p2_id_q     <= p1_id_q;
            p2_we_q     <= p1_we_q;
            rsp_valid_q <= p2_valid_q ? (NUM_REQ'(1) << p2_id_q) : '0;
            rsp_rdata_q <= (p2_valid_q && !p2_we_q) ? mem_douta_i : '0;
        end
    end

    // A registered write strobe must not reach data_mem once reset is seen
    assign mem_wea_o   = mem_wea_q & ~rst_i;
    assign mem_addra_o = mem_addra_q;
    assign mem_dina_o  = mem_dina_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] grant_cnt_q [NUM_REQ];
    logic [15:0] conflict_cnt_q;

    // Saturating accept counters per requester and a multi-request conflict counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
            conflict_cnt_q <= '0;
        end else begin
            if (gnt_found && grant_cnt_q[gnt_id] != 16'hFFFF) begin
                grant_cnt_q[gnt_id] <= grant_cnt_q[gnt_id] + 16'd1;
            end
            if ($countones(req_valid_i) > 1 && conflict_cnt_q != 16'hFFFF) begin
                conflict_cnt_q <= conflict_cnt_q + 16'd1;
            end
        end
    end

    // Flatten the counter array onto the output bus
    always_comb begin
        grant_cnt_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt_o[i*16 +: 16] = grant_cnt_q[i];
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_dmem_arbiter;

    localparam int N  = 2;
    localparam int AW = 15;
    localparam int W  = 32;
    localparam int MB = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_lock  = '0;
    logic [N-1:0]    req_we    = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N*W-1:0]  req_wdata = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [W-1:0]    rsp_rdata;
    logic            mem_wea;
    logic [AW-1:0]   mem_addra;
    logic [W-1:0]    mem_dina;
    logic [W-1:0]    mem_douta;
`ifdef DMEM_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
    logic [15:0]     conflict_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .NUM_REQ(N), .MEM_WIDTH(W), .MEM_ADDR_WIDTH(AW), .MAX_BURST(MB)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_lock_i(req_lock), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .mem_wea_o(mem_wea), .mem_addra_o(mem_addra), .mem_dina_o(mem_dina),
        .mem_douta_i(mem_douta)
`ifdef DMEM_ARB_STATS_EN
        , .grant_cnt_o(grant_cnt), .conflict_cnt_o(conflict_cnt)
`endif
    );

    function automatic logic [W-1:0] init_val(input logic [AW-1:0] a);
        return 32'h5A000000 ^ (32'(a) * 32'h00010003);
    endfunction

    // data_mem stand-in: synchronous write, one-cycle registered read
    logic [W-1:0] env_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_wea) env_mem[mem_addra] <= mem_dina;
        mem_douta <= env_mem[mem_addra];
    end

    // Reference memory contents: initial pattern overlaid with writes in accept order
    logic [W-1:0] ref_wr [int];
    function automatic logic [W-1:0] ref_rd(input logic [AW-1:0] a);
        if (ref_wr.exists(int'(a))) return ref_wr[int'(a)];
        return init_val(a);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model state: free/owned arbitration, and the responses due 1..3 cycles on
    int            m_ptr = 0;
    int            m_own = -1;
    int            m_cnt = 0;
    logic          h_v    [1:3] = '{default: 1'b0};
    int            h_id   [1:3] = '{default: 0};
    logic          h_we   [1:3] = '{default: 1'b0};
    logic [W-1:0]  h_data [1:3] = '{default: '0};
    logic [AW-1:0] m_addr  = '0;
    logic [W-1:0]  m_wdata = '0;
    int            m_gcnt [N] = '{default: 0};
    int            m_conf = 0;

    always @(negedge clk) begin : compare
        int            g;
        int            run;
        logic [N-1:0]  oh;
        logic [N-1:0]  others;
        logic [AW-1:0] a;
        logic [W-1:0]  d;
        oh = '0;
        if (h_v[3]) oh[h_id[3]] = 1'b1;
        chk("rsp_valid", rsp_valid, oh);
        if (h_v[3]) chk("rsp_rdata", rsp_rdata, h_data[3]);
        chk("mem_wea", mem_wea, h_v[1] && h_we[1] && !rst);
        chk("mem_addra", mem_addra, m_addr);
        chk("mem_dina", mem_dina, m_wdata);
`ifdef DMEM_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("grant_cnt", grant_cnt[i*16 +: 16], m_gcnt[i]);
        chk("conflict_cnt", conflict_cnt, m_conf);
`endif
        g = -1;
        if (!rst) begin
            if (m_own >= 0) begin
                if (req_valid[m_own]) g = m_own;
            end else begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        oh = '0;
        if (g >= 0) oh[g] = 1'b1;
        chk("req_ready", req_ready, oh);

        h_v[3] = h_v[2]; h_id[3] = h_id[2]; h_we[3] = h_we[2]; h_data[3] = h_data[2];
        h_v[2] = h_v[1]; h_id[2] = h_id[1]; h_we[2] = h_we[1]; h_data[2] = h_data[1];
        h_v[1] = 1'b0;
        if (rst) begin
            m_ptr = 0; m_own = -1; m_cnt = 0;
            h_v[2] = 1'b0; h_v[3] = 1'b0;
            m_addr = '0; m_wdata = '0;
            for (int i = 0; i < N; i++) m_gcnt[i] = 0;
            m_conf = 0;
        end else begin
            if ($countones(req_valid) > 1 && m_conf < 65535) m_conf++;
            if (g >= 0) begin
                a = req_addr[g*AW +: AW];
                d = req_wdata[g*W +: W];
                others = req_valid;
                others[g] = 1'b0;
                run = (m_own >= 0) ? ((m_cnt + 1 > MB) ? MB : m_cnt + 1) : 1;
                if (req_lock[g] && !(run >= MB && others != '0)) begin
                    m_own = g; m_cnt = run;
                end else begin
                    m_own = -1; m_cnt = 0;
                end
                m_ptr = (g + 1) % N;
                h_v[1] = 1'b1; h_id[1] = g; h_we[1] = req_we[g];
                if (req_we[g]) begin
                    ref_wr[int'(a)] = d;
                    h_data[1] = '0;
                end else begin
                    h_data[1] = ref_rd(a);
                end
                m_addr = a; m_wdata = d;
                if (m_gcnt[g] < 65535) m_gcnt[g]++;
            end else if (m_own >= 0 && !req_valid[m_own]) begin
                m_own = -1; m_cnt = 0;
            end
        end
    end

    task automatic set_req(input int i, input logic v, input logic l, input logic w,
                           input logic [AW-1:0] a, input logic [W-1:0] d);
        req_valid[i] = v;
        req_lock[i]  = l;
        req_we[i]    = w;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*W +: W]  = d;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    logic [N-1:0] seq [0:9];
    int           n0, n1, ns, wea_cnt, nrsp;
    logic [N-1:0] acc;

    initial begin
        for (int i = 0; i < (1 << AW); i++) env_mem[i] = init_val(AW'(i));
        env_mem[16] = 32'hDEADBEEF;
        ref_wr[16]  = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single read: grant same cycle, address next cycle, data 3 cycles after accept
        set_req(0, 1'b1, 1'b0, 1'b0, 15'h0010, '0);
        @(negedge clk); chk("t1_ready", req_ready, 2'b01);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk); chk("t1_addra", mem_addra, 15'h0010);
        @(negedge clk); chk("t1_rsp_early", rsp_valid, 2'b00);
        @(negedge clk); chk("t1_rsp_valid", rsp_valid, 2'b01);
        chk("t1_rdata", rsp_rdata, 32'hDEADBEEF);

        // Round-robin alternation, starting at requester 0 after reset
        do_reset();
        set_req(0, 1'b1, 1'b0, 1'b0, 15'h0001, '0);
        set_req(1, 1'b1, 1'b0, 1'b0, 15'h0002, '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); seq[k] = req_ready;
            @(posedge clk); #1;
        end
        req_valid = '0;
        chk("rr_g0", seq[0], 2'b01); chk("rr_g1", seq[1], 2'b10);
        chk("rr_g2", seq[2], 2'b01); chk("rr_g3", seq[3], 2'b10);

        // Locked burst from requester 1, requester 0 arrives on the third cycle
        do_reset();
        n0 = 0; n1 = 0; ns = 0;
        for (int c = 0; c < 40; c++) begin
            set_req(1, n1 < 20, n1 < 19, 1'b1, 15'(32'h0100 + n1), 32'hB0000000 + n1);
            set_req(0, c >= 2 && n0 < 1, 1'b0, 1'b0, 15'h0100, '0);
            @(negedge clk);
            if (req_valid[1] && req_ready[1]) begin
                if (ns < 10) begin seq[ns] = 2'b10; ns++; end
                n1++;
            end
            if (req_valid[0] && req_ready[0]) begin
                if (ns < 10) begin seq[ns] = 2'b01; ns++; end
                n0++;
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        for (int k = 0; k < 10; k++)
            chk($sformatf("burst_g%0d", k), seq[k], (k == 8) ? 2'b01 : 2'b10);
        chk("burst_n1", n1, 20);
        chk("burst_n0", n0, 1);

        // Write then read of the same address on consecutive cycles
        do_reset();
        set_req(0, 1'b1, 1'b0, 1'b1, 15'h7FFF, 32'h12345678);
        @(negedge clk); chk("wr_ready", req_ready, 2'b01);
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 1'b0, 15'h7FFF, '0);
        @(negedge clk); chk("rd_ready", req_ready, 2'b01);
        wea_cnt = int'(mem_wea);
        @(posedge clk); #1 req_valid = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            wea_cnt += int'(mem_wea);
            if (k == 1) begin
                chk("wr_ack_valid", rsp_valid, 2'b01);
                chk("wr_ack_rdata", rsp_rdata, 32'h0);
            end
            if (k == 2) begin
                chk("rd_valid", rsp_valid, 2'b01);
                chk("rd_rdata", rsp_rdata, 32'h12345678);
            end
        end
        chk("wea_pulses", wea_cnt, 1);

        // Reset while a read is in flight: nothing comes back
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 1'b0, 15'h0020, '0);
        @(negedge clk); chk("rmf_ready", req_ready, 2'b01);
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        nrsp = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) nrsp++;
            if (k == 2) begin
                chk("rmf_rsp_rdata", rsp_rdata, 32'h0);
                chk("rmf_wea", mem_wea, 1'b0);
                chk("rmf_addra", mem_addra, 15'h0);
                chk("rmf_dina", mem_dina, 32'h0);
            end
            @(posedge clk); #1;
            if (k == 1) rst = 1'b0;
        end
        chk("rmf_no_rsp", nrsp, 0);
        set_req(0, 1'b1, 1'b0, 1'b0, 15'h0003, '0);
        set_req(1, 1'b1, 1'b0, 1'b0, 15'h0004, '0);
        @(negedge clk); chk("rmf_first_grant", req_ready, 2'b01);
        @(posedge clk); #1 req_valid = '0;

        // Randomized traffic; requests stay stable until accepted or dropped
        acc = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    set_req(i, $urandom_range(0, 99) < 55, $urandom_range(0, 3) == 0,
                            1'($urandom_range(0, 1)),
                            ($urandom_range(0, 7) == 0) ? 15'h7FFF : 15'($urandom_range(0, 15)),
                            $urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rst = (c % 700 == 350);
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        req_valid = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
